// File: rtl/mm_cmd_arbiter.sv
// Round-robin command sequencer between locality requesters and management_module.
// Grants one requester, strobes keyStart, waits a fixed window, returns the response code.
module mm_cmd_arbiter #(
  parameter int unsigned NUM_REQ      = 5,
  parameter int unsigned START_CYCLES = 2,
  parameter int unsigned RSP_WAIT     = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [32*NUM_REQ-1:0]  cc_i,
  input  logic [33*NUM_REQ-1:0]  param_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [31:0]            rc_o,
  output logic                   busy_o,
  output logic [15:0]            cmd_count_o,
  output logic                   mm_keyStart_n_o,
  output logic [31:0]            mm_tpm_cc_o,
  output logic [32:0]            mm_cmd_param_o,
  output logic [7:0]             mm_locality_o,
  input  logic [31:0]            mm_tpm_rc_i
);

  localparam int unsigned IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_PHASE = (START_CYCLES > RSP_WAIT) ? START_CYCLES : RSP_WAIT;
  localparam int unsigned CNT_W     = $clog2(MAX_PHASE + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   grantIdx;
  logic [CNT_W-1:0]   phaseCnt;

  logic               pickValid;
  logic [IDX_W-1:0]   pickIdx;
  int unsigned        cand;
  logic [31:0]        ccArr    [NUM_REQ];
  logic [32:0]        paramArr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : gSlice
    assign ccArr[k]    = cc_i[32*k +: 32];
    assign paramArr[k] = param_i[33*k +: 33];
  end

  // First requesting index at or after the pointer, wrapping around.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rrPtr) + i) % NUM_REQ;
      if (!pickValid && req_i[IDX_W'(cand)]) begin
        pickValid = 1'b1;
        pickIdx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= IDLE;
      rrPtr           <= '0;
      grantIdx        <= '0;
      phaseCnt        <= '0;
      grant_o         <= '0;
      done_o          <= '0;
      rc_o            <= '0;
      busy_o          <= 1'b0;
      cmd_count_o     <= '0;
      mm_keyStart_n_o <= 1'b1;
      mm_tpm_cc_o     <= '0;
      mm_cmd_param_o  <= '0;
      mm_locality_o   <= '0;
    end else begin
      done_o <= '0;
      case (state)
        IDLE: begin
          if (pickValid) begin
            state           <= ISSUE;
            grant_o         <= NUM_REQ'(1) << pickIdx;
            grantIdx        <= pickIdx;
            mm_tpm_cc_o     <= ccArr[pickIdx];
            mm_cmd_param_o  <= paramArr[pickIdx];
            mm_locality_o   <= 8'(pickIdx);
            mm_keyStart_n_o <= 1'b0;
            busy_o          <= 1'b1;
            phaseCnt        <= '0;
          end
        end
        ISSUE: begin
          if (phaseCnt == CNT_W'(START_CYCLES - 1)) begin
            state           <= WAIT;
            mm_keyStart_n_o <= 1'b1;
            phaseCnt        <= '0;
          end else begin
            phaseCnt <= phaseCnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (phaseCnt == CNT_W'(RSP_WAIT - 1)) begin
            state  <= DONE;
            rc_o   <= mm_tpm_rc_i;
            done_o <= grant_o;
            if (cmd_count_o != 16'hFFFF) begin
              cmd_count_o <= cmd_count_o + 16'd1;
            end
          end else begin
            phaseCnt <= phaseCnt + CNT_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
          rrPtr   <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
